// File: rtl/user_obi_scratchpad.sv
// user_obi_scratchpad
//   OBI subordinate backed by a flop-based word memory. Every accepted
//   request gets exactly one response, a fixed Latency cycles after its
//   grant, in grant order. Addresses outside [BaseAddr, BaseAddr+NumWords*4)
//   get an error response and never touch the memory.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i              address-phase request
//   addr_i             byte address (bits [1:0] ignored)
//   we_i               1 = write, 0 = read
//   be_i               byte enables (writes only)
//   wdata_i            write data
//   aid_i              request ID
//   gnt_o              address-phase grant (combinational)
//   rvalid_o           response valid, one-cycle pulse (registered)
//   rdata_o            read data, 0 for writes and errors (registered)
//   rid_o              response ID (registered)
//   err_o              error response (registered)
module user_obi_scratchpad #(
  parameter int unsigned           AddrWidth = 32,
  parameter int unsigned           DataWidth = 32,
  parameter int unsigned           IdWidth   = 1,
  parameter int unsigned           NumWords  = 64,
  parameter logic [AddrWidth-1:0]  BaseAddr  = 32'h2000_1000,
  parameter int unsigned           Latency   = 1,
  parameter int unsigned           MaxTrans  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [IdWidth-1:0]     aid_i,
  output logic                   gnt_o,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [IdWidth-1:0]     rid_o,
  output logic                   err_o
);

  localparam int unsigned IdxW = $clog2(NumWords);
  localparam int unsigned BeW  = DataWidth / 8;
  localparam int unsigned CntW = 3;

  // Address decode
  logic [AddrWidth-1:0] offset;
  logic                 in_range;
  logic [IdxW-1:0]      idx;

  assign offset   = addr_i - BaseAddr;
  assign in_range = (offset < AddrWidth'(NumWords * 4));
  assign idx      = offset[2 +: IdxW];

  // Outstanding tracking and grant
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_eff;
  logic            accept;

  // The response retiring this cycle already frees its slot, so a new
  // grant can coincide with rvalid_o even when the counter is at MaxTrans.
  assign cnt_eff = cnt_q - {{(CntW-1){1'b0}}, rvalid_o};
  assign gnt_o   = req_i && rst_ni && (cnt_eff < CntW'(MaxTrans));
  assign accept  = req_i && gnt_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + {{(CntW-1){1'b0}}, accept} - {{(CntW-1){1'b0}}, rvalid_o};
    end
  end

  // Word memory
  logic [DataWidth-1:0] mem_q [NumWords];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned w = 0; w < NumWords; w++) begin
        mem_q[w] <= '0;
      end
    end else if (accept && we_i && in_range) begin
      for (int unsigned b = 0; b < BeW; b++) begin
        if (be_i[b]) begin
          mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline. Write and error responses enter with zero data, so
  // the write flag does not need to travel down the stages.
  logic [Latency-1:0]   pipe_valid;
  logic [Latency-1:0]   pipe_err;
  logic [IdWidth-1:0]   pipe_id   [Latency];
  logic [DataWidth-1:0] pipe_data [Latency];

  logic [DataWidth-1:0] rd_word;
  logic [IdWidth-1:0]   rd_id;

  // Sampling mem_q before its update gives a same-cycle read the old value.
  always_comb begin
    rd_word = '0;
    rd_id   = '0;
    if (accept) begin
      rd_id = aid_i;
      if (!we_i && in_range) begin
        rd_word = mem_q[idx];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int unsigned i = 0; i < Latency; i++) begin
        pipe_id[i]   <= '0;
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept && !in_range;
      pipe_id[0]    <= rd_id;
      pipe_data[0]  <= rd_word;
      for (int unsigned i = 1; i < Latency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_id[i]    <= pipe_id[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid[Latency-1];
  assign err_o    = pipe_err[Latency-1];
  assign rid_o    = pipe_id[Latency-1];
  assign rdata_o  = pipe_data[Latency-1];

endmodule

// File: tb/tb_user_obi_scratchpad.sv
// Testbench for user_obi_scratchpad: two instances (Latency 1 and 4, both
// MaxTrans 2) share one request bus; a per-instance reference model of
// scheduled responses checks every cycle, plus directed checks.
module tb_user_obi_scratchpad;

  localparam logic [31:0] BASE = 32'h2000_1000;
  localparam int          NW   = 64;
  localparam int          L0   = 1;
  localparam int          L1   = 4;
  localparam int          MT   = 2;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        aid;

  logic [1:0]  gnt_v, rv_v, err_v, rid_v;
  logic [31:0] rd0, rd1;

  int n_cmp = 0;
  int n_err = 0;

  user_obi_scratchpad #(
    .NumWords(NW), .BaseAddr(BASE), .Latency(L0), .MaxTrans(MT)
  ) u_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .aid_i(aid), .gnt_o(gnt_v[0]),
    .rvalid_o(rv_v[0]), .rdata_o(rd0), .rid_o(rid_v[0:0]), .err_o(err_v[0])
  );

  user_obi_scratchpad #(
    .NumWords(NW), .BaseAddr(BASE), .Latency(L1), .MaxTrans(MT)
  ) u_lat4 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .aid_i(aid), .gnt_o(gnt_v[1]),
    .rvalid_o(rv_v[1]), .rdata_o(rd1), .rid_o(rid_v[1:1]), .err_o(err_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: memory image per instance and responses scheduled by
  // the cycle they are due, in a ring keyed by cycle number.
  logic [31:0] mmem [2][NW];
  bit          sv   [2][8];
  logic [31:0] sd   [2][8];
  bit          se   [2][8];
  logic        sid  [2][8];
  int          pend [2];
  int unsigned cyc = 0;

  always @(negedge clk) begin : model
    int unsigned s, due, idx;
    logic [31:0] off, d, rd;
    bit inr, eg;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        pend[k] = 0;
        for (int j = 0; j < 8; j++) sv[k][j] = 0;
        for (int w = 0; w < NW; w++) mmem[k][w] = '0;
        rd = (k == 0) ? rd0 : rd1;
        check($sformatf("u%0d.rst.gnt", k), gnt_v[k], 0);
        check($sformatf("u%0d.rst.rvalid", k), rv_v[k], 0);
        check($sformatf("u%0d.rst.rdata", k), rd, 0);
        check($sformatf("u%0d.rst.rid", k), rid_v[k], 0);
        check($sformatf("u%0d.rst.err", k), err_v[k], 0);
      end
    end else begin
      s = cyc % 8;
      for (int k = 0; k < 2; k++) begin
        rd = (k == 0) ? rd0 : rd1;
        if (sv[k][s]) begin
          check($sformatf("u%0d.rvalid", k), rv_v[k], 1);
          check($sformatf("u%0d.rdata", k), rd, sd[k][s]);
          check($sformatf("u%0d.err", k), err_v[k], se[k][s]);
          check($sformatf("u%0d.rid", k), rid_v[k], sid[k][s]);
          sv[k][s] = 0;
          pend[k]--;
        end else begin
          check($sformatf("u%0d.rvalid_idle", k), rv_v[k], 0);
        end
        eg = req && (pend[k] < MT);
        check($sformatf("u%0d.gnt", k), gnt_v[k], eg);
        if (eg) begin
          off = addr - BASE;
          inr = (off < NW * 4);
          idx = (off >> 2) % NW;
          d = '0;
          if (inr && !we) d = mmem[k][idx];
          if (inr && we)
            for (int b = 0; b < 4; b++)
              if (be[b]) mmem[k][idx][8*b +: 8] = wdata[8*b +: 8];
          due = (cyc + ((k == 0) ? L0 : L1)) % 8;
          sv[k][due]  = 1;
          sd[k][due]  = d;
          se[k][due]  = !inr;
          sid[k][due] = aid;
          pend[k]++;
        end
      end
      cyc++;
    end
  end

  task automatic idle();
    req = 0; we = 0; be = '0; wdata = '0; aid = 0; addr = '0;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [3:0] b,
                       input logic [31:0] d, input logic id);
    req = 1; we = w; addr = a; be = b; wdata = d; aid = id;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
    drive(1, a, b, d, 0);
    @(posedge clk); #1 idle();
  endtask

  // Read on the Latency-1 instance; response visible in the following cycle.
  task automatic rd0_chk(input string tag, input logic [31:0] a, input logic id,
                         input logic [31:0] exp_d, input logic exp_e);
    drive(0, a, 4'h0, 32'h0, id);
    @(negedge clk) check({tag, ".gnt"}, gnt_v[0], 1);
    @(posedge clk); #1 idle();
    @(negedge clk);
    check({tag, ".rvalid"}, rv_v[0], 1);
    check({tag, ".rdata"}, rd0, exp_d);
    check({tag, ".err"}, err_v[0], exp_e);
    check({tag, ".rid"}, rid_v[0], id);
    @(posedge clk); #1;
  endtask

  task automatic rand_op();
    int sel, word;
    req   = ($urandom % 4) != 0;
    we    = $urandom % 2;
    be    = ($urandom % 8 == 0) ? 4'h0 : 4'($urandom);
    wdata = $urandom;
    aid   = $urandom % 2;
    sel   = $urandom % 10;
    word  = ($urandom % 2) ? ($urandom % 8) : ($urandom % NW);
    if (sel < 7)       addr = BASE + 32'(word * 4) + ($urandom % 4);
    else if (sel == 7) addr = BASE + NW * 4 + ($urandom % 16) * 4;
    else if (sel == 8) addr = BASE - 4 - ($urandom % 64) * 4;
    else               addr = $urandom;
  endtask

  logic [9:0] g_seen, v_seen;
  logic [1:0] id_seen [10];
  bit         ghost;

  initial begin
    rst_n = 0;
    drive(0, BASE, 4'h0, 32'h0, 1);
    @(negedge clk);
    check("rst.gnt_lat1", gnt_v[0], 0);
    check("rst.gnt_lat4", gnt_v[1], 0);
    @(posedge clk); #1 rst_n = 1; idle();
    @(posedge clk); #1;

    rd0_chk("rst_read", BASE, 1, 32'h0, 0);

    wr(BASE + 8, 4'b0101, 32'hDEAD_BEEF);
    rd0_chk("be_read", BASE + 8, 0, 32'h00AD_00EF, 0);

    wr(BASE, 4'hF, 32'hA5A5_A5A5);
    wr(BASE + NW * 4, 4'hF, 32'h1234_5678);
    rd0_chk("oor_wr_word0", BASE, 0, 32'hA5A5_A5A5, 0);
    rd0_chk("oor_read", 32'h2000_0FFC, 1, 32'h0, 1);
    wr(BASE + 12, 4'h0, 32'hFFFF_FFFF);
    rd0_chk("be0_noop", BASE + 12, 0, 32'h0, 0);

    // Write then read next cycle sees the new value.
    drive(1, BASE + 12, 4'hF, 32'h1111_2222, 0);
    @(posedge clk); #1 drive(0, BASE + 12, 4'h0, 32'h0, 1);
    @(posedge clk); #1 idle();
    @(negedge clk) check("haz.wr_rd", rd0, 32'h1111_2222);
    // Read then write next cycle: read returns the old value.
    @(posedge clk); #1 drive(0, BASE + 12, 4'h0, 32'h0, 0);
    @(posedge clk); #1 drive(1, BASE + 12, 4'hF, 32'h3333_4444, 1);
    @(negedge clk) check("haz.rd_wr", rd0, 32'h1111_2222);
    @(posedge clk); #1 idle();
    rd0_chk("haz.after", BASE + 12, 1, 32'h3333_4444, 0);

    // Backpressure on the Latency-4 instance with req held high.
    repeat (6) @(posedge clk);
    #1;
    for (int c = 0; c < 10; c++) begin
      drive(0, BASE + 32'(c * 4), 4'h0, 32'h0, c[0]);
      @(negedge clk);
      g_seen[c] = gnt_v[1];
      v_seen[c] = rv_v[1];
      id_seen[c] = {1'b0, rid_v[1]};
      @(posedge clk); #1;
    end
    idle();
    check("bp.gnt_pattern", 32'(g_seen), 32'(10'b1100110011));
    check("bp.rvalid_pattern", 32'(v_seen), 32'(10'b1100110000));
    check("bp.rid_c4", 32'(id_seen[4]), 0);
    check("bp.rid_c5", 32'(id_seen[5]), 1);
    check("bp.rid_c8", 32'(id_seen[8]), 0);

    // Reset with two reads in flight on the Latency-4 instance.
    repeat (6) @(posedge clk);
    #1 drive(0, BASE, 4'h0, 32'h0, 0);
    @(posedge clk); #1 drive(0, BASE + 4, 4'h0, 32'h0, 1);
    @(posedge clk); #1 idle(); rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    ghost = 0;
    repeat (8) begin
      @(negedge clk) ghost |= rv_v[1];
    end
    check("midrst.no_rvalid", ghost, 0);
    @(posedge clk); #1 drive(0, BASE, 4'h0, 32'h0, 1);
    @(negedge clk) check("midrst.gnt", gnt_v[1], 1);
    @(posedge clk); #1 idle();

    // Randomized traffic, with one reset pulse in the middle.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        idle(); rst_n = 0;
        @(posedge clk); #1 rst_n = 1;
      end
      rand_op();
      @(posedge clk); #1;
    end
    idle();
    repeat (8) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
